// File: rtl/hex_msg_scheduler.sv
// Arbitrates the six 7-segment digits between prioritised maze-game event messages
// and live controller-button echo; event messages are held, gapped, or latched.
module hex_msg_scheduler #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       a,
    input  logic       b,
    input  logic       ev_start,
    input  logic       ev_tp,
    input  logic       ev_dead,
    input  logic       ev_clear,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [3:0] msg_code,
    output logic       busy
);

    localparam int MAX_C = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    localparam logic [3:0] MSG_BLANK = 4'd0;
    localparam logic [3:0] MSG_UP    = 4'd1;
    localparam logic [3:0] MSG_DO    = 4'd2;
    localparam logic [3:0] MSG_LE    = 4'd3;
    localparam logic [3:0] MSG_RI    = 4'd4;
    localparam logic [3:0] MSG_A     = 4'd5;
    localparam logic [3:0] MSG_B     = 4'd6;
    localparam logic [3:0] MSG_START = 4'd7;
    localparam logic [3:0] MSG_TP    = 4'd8;
    localparam logic [3:0] MSG_DEAD  = 4'd9;
    localparam logic [3:0] MSG_CLEAR = 4'd10;

    localparam logic [6:0] BL = 7'b1111111;

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP, S_LATCH} state_t;

    // Returns {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}
    function automatic logic [41:0] glyph(input logic [3:0] m);
        case (m)
            MSG_UP:    glyph = {BL, BL, BL, BL, 7'b1000001, 7'b0001100};
            MSG_DO:    glyph = {BL, BL, BL, BL, 7'b0100001, 7'b0100011};
            MSG_LE:    glyph = {BL, BL, BL, BL, 7'b1000111, 7'b0000110};
            MSG_RI:    glyph = {BL, BL, BL, BL, 7'b1001110, 7'b1001111};
            MSG_A:     glyph = {BL, BL, BL, BL, BL, 7'b0001000};
            MSG_B:     glyph = {BL, BL, BL, BL, BL, 7'b0000011};
            MSG_START: glyph = {BL, 7'b0010010, 7'b0000111, 7'b0001000, 7'b0101111, 7'b0000111};
            MSG_TP:    glyph = {BL, BL, BL, BL, 7'b0000111, 7'b0001100};
            MSG_DEAD:  glyph = {BL, BL, 7'b0100001, 7'b0000110, 7'b0001000, 7'b0100001};
            MSG_CLEAR: glyph = {BL, 7'b1000110, 7'b1000111, 7'b0000110, 7'b0001000, 7'b0101111};
            default:   glyph = {BL, BL, BL, BL, BL, BL};
        endcase
    endfunction

    // Event vectors are {clear, dead, start, tp}: bit order is priority order.
    function automatic logic [3:0] pick(input logic [3:0] v);
        if (v[3])      pick = 4'b1000;
        else if (v[2]) pick = 4'b0100;
        else if (v[1]) pick = 4'b0010;
        else if (v[0]) pick = 4'b0001;
        else           pick = 4'b0000;
    endfunction

    function automatic logic [3:0] msg_of(input logic [3:0] g);
        if (g[3])      msg_of = MSG_CLEAR;
        else if (g[2]) msg_of = MSG_DEAD;
        else if (g[1]) msg_of = MSG_START;
        else           msg_of = MSG_TP;
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    msg_q, msg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pend_q, pend_d;
    logic [41:0]   hex_q, hex_d;

    logic [3:0] pulses, cand, gsrc, gbit, pend_base, shown, hi_mask, echo_msg;
    logic       do_grant;

    always_comb begin
        echo_msg = MSG_BLANK;
        case ({up, down, left, right})
            4'b1000: echo_msg = MSG_UP;
            4'b0100: echo_msg = MSG_DO;
            4'b0010: echo_msg = MSG_LE;
            4'b0001: echo_msg = MSG_RI;
            4'b0000: begin
                if (a && !b)      echo_msg = MSG_A;
                else if (b && !a) echo_msg = MSG_B;
            end
            default: echo_msg = MSG_BLANK;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        do_grant  = 1'b0;
        gsrc      = 4'b0000;
        gbit      = 4'b0000;
        pulses    = {ev_clear, ev_dead, ev_start, ev_tp};
        cand      = pend_q | pulses;
        pend_base = pend_q;
        shown     = (msg_q == MSG_START) ? 4'b0010 : 4'b0001;
        hi_mask   = (msg_q == MSG_START) ? 4'b1100 : 4'b1110;

        case (state_q)
            S_IDLE: begin
                if (|cand) begin
                    do_grant  = 1'b1;
                    gsrc      = cand;
                    pend_base = cand;
                end else begin
                    msg_d = echo_msg;
                end
            end
            S_SHOW: begin
                // Re-pulsing the message on screen is neither shown again nor queued.
                pend_base = pend_q | (pulses & ~shown);
                if (|(pulses & hi_mask)) begin
                    do_grant = 1'b1;
                    gsrc     = pulses & hi_mask;
                end else begin
                    pend_d = pend_base;
                    if (cnt_q == '0) begin
                        if (GAP_CYCLES == 0) begin
                            state_d = S_IDLE;
                            msg_d   = echo_msg;
                        end else begin
                            state_d = S_GAP;
                            msg_d   = MSG_BLANK;
                            cnt_d   = GAP_LD;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_GAP: begin
                pend_base = pend_q | pulses;
                if (ev_clear || ev_dead) begin
                    do_grant = 1'b1;
                    gsrc     = pulses & 4'b1100;
                end else begin
                    pend_d = pend_base;
                    msg_d  = MSG_BLANK;
                    // Leaving the gap echoes buttons at once; pending events wait one cycle.
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        msg_d   = echo_msg;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_LATCH: begin
                if (ev_clear && msg_q == MSG_DEAD) begin
                    msg_d = MSG_CLEAR;
                end else if (ev_start && !ev_clear) begin
                    state_d = S_SHOW;
                    msg_d   = MSG_START;
                    cnt_d   = HOLD_LD;
                    pend_d  = 4'b0000;
                end
            end
            default: begin
                state_d = S_IDLE;
                msg_d   = MSG_BLANK;
            end
        endcase

        if (do_grant) begin
            gbit   = pick(gsrc);
            pend_d = pend_base & ~gbit;
            msg_d  = msg_of(gbit);
            if (gbit[3] || gbit[2]) begin
                state_d     = S_LATCH;
                cnt_d       = '0;
                pend_d[1:0] = 2'b00;
            end else begin
                state_d = S_SHOW;
                cnt_d   = HOLD_LD;
            end
        end
    end

    assign hex_d = glyph(msg_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            msg_q   <= MSG_BLANK;
            cnt_q   <= '0;
            pend_q  <= 4'b0000;
            hex_q   <= {6{BL}};
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hex_q   <= hex_d;
        end
    end

    assign HEX0     = hex_q[6:0];
    assign HEX1     = hex_q[13:7];
    assign HEX2     = hex_q[20:14];
    assign HEX3     = hex_q[27:21];
    assign HEX4     = hex_q[34:28];
    assign HEX5     = hex_q[41:35];
    assign msg_code = msg_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_hex_msg_scheduler.sv
// Directed bench for hex_msg_scheduler: button echo, hold/gap timing, priority
// preemption, pending events, latched terminal messages and asynchronous reset.
module tb_hex_msg_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, a = 1'b0, b = 1'b0;
    logic       ev_start = 1'b0, ev_tp = 1'b0, ev_dead = 1'b0, ev_clear = 1'b0;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [3:0] msg_code;
    logic       busy;
    logic [41:0] hex_all;

    int n_chk  = 0;
    int n_fail = 0;

    hex_msg_scheduler #(.HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .up(up), .down(down), .left(left), .right(right), .a(a), .b(b),
        .ev_start(ev_start), .ev_tp(ev_tp), .ev_dead(ev_dead), .ev_clear(ev_clear),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
        .msg_code(msg_code), .busy(busy)
    );

    always #5 clk = ~clk;

    assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    localparam logic [6:0] BL = 7'b1111111;

    function automatic logic [41:0] exp_hex(input int code);
        case (code)
            1:       exp_hex = {BL, BL, BL, BL, 7'b1000001, 7'b0001100};
            2:       exp_hex = {BL, BL, BL, BL, 7'b0100001, 7'b0100011};
            3:       exp_hex = {BL, BL, BL, BL, 7'b1000111, 7'b0000110};
            4:       exp_hex = {BL, BL, BL, BL, 7'b1001110, 7'b1001111};
            5:       exp_hex = {BL, BL, BL, BL, BL, 7'b0001000};
            6:       exp_hex = {BL, BL, BL, BL, BL, 7'b0000011};
            7:       exp_hex = {BL, 7'b0010010, 7'b0000111, 7'b0001000, 7'b0101111, 7'b0000111};
            8:       exp_hex = {BL, BL, BL, BL, 7'b0000111, 7'b0001100};
            9:       exp_hex = {BL, BL, 7'b0100001, 7'b0000110, 7'b0001000, 7'b0100001};
            10:      exp_hex = {BL, 7'b1000110, 7'b1000111, 7'b0000110, 7'b0001000, 7'b0101111};
            default: exp_hex = {6{BL}};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic see(input string tag, input int code, input logic bsy);
        check({tag, "_msg"}, 64'(msg_code), 64'(code));
        check({tag, "_hex"}, 64'(hex_all), 64'(exp_hex(code)));
        check({tag, "_busy"}, 64'(busy), 64'(bsy));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        see("reset", 0, 1'b0);
        reset_n = 1'b1;
        step();
        see("idle", 0, 1'b0);

        // Button echo
        up = 1'b1;
        step(); see("up_a", 1, 1'b0);
        step(); see("up_b", 1, 1'b0);
        step(); see("up_c", 1, 1'b0);
        down = 1'b1;
        step(); see("up_down", 0, 1'b0);
        up = 1'b0;
        step(); see("down", 2, 1'b0);
        down = 1'b0; left = 1'b1;
        step(); see("left", 3, 1'b0);
        left = 1'b0; b = 1'b1;
        step(); see("btn_b", 6, 1'b0);
        a = 1'b1;
        step(); see("a_and_b", 0, 1'b0);
        b = 1'b0;
        step(); see("btn_a", 5, 1'b0);
        a = 1'b0;

        // START with right held: 4 shown, 2 gap, then RI
        right = 1'b1; ev_start = 1'b1;
        step(); see("st_0", 7, 1'b1);
        ev_start = 1'b0;
        for (int i = 1; i < 4; i++) begin step(); see("st_hold", 7, 1'b1); end
        for (int i = 0; i < 2; i++) begin step(); see("st_gap", 0, 1'b1); end
        step(); see("st_ri", 4, 1'b0);
        right = 1'b0;
        step(); see("st_idle", 0, 1'b0);

        // TP preempted by START; TP dropped
        ev_tp = 1'b1;
        step(); see("tp_0", 8, 1'b1);
        ev_tp = 1'b0; ev_start = 1'b1;
        step(); see("pre_0", 7, 1'b1);
        ev_start = 1'b0;
        for (int i = 1; i < 4; i++) begin step(); see("pre_hold", 7, 1'b1); end
        for (int i = 0; i < 2; i++) begin step(); see("pre_gap", 0, 1'b1); end
        step(); see("pre_idle", 0, 1'b0);
        step(); see("pre_no_tp", 0, 1'b0);

        // START then TP pends behind it
        ev_start = 1'b1;
        step(); see("pd_st0", 7, 1'b1);
        ev_start = 1'b0;
        step(); see("pd_st1", 7, 1'b1);
        ev_tp = 1'b1;
        step(); see("pd_st2", 7, 1'b1);
        ev_tp = 1'b0;
        step(); see("pd_st3", 7, 1'b1);
        for (int i = 0; i < 2; i++) begin step(); see("pd_gap1", 0, 1'b1); end
        step(); see("pd_idle1", 0, 1'b0);
        step(); see("pd_tp0", 8, 1'b1);
        for (int i = 1; i < 4; i++) begin step(); see("pd_tp", 8, 1'b1); end
        for (int i = 0; i < 2; i++) begin step(); see("pd_gap2", 0, 1'b1); end
        step(); see("pd_idle2", 0, 1'b0);

        // DEAD preempts START, latches, then CLEAR, then START exits
        ev_start = 1'b1;
        step(); see("dd_st", 7, 1'b1);
        ev_start = 1'b0; ev_dead = 1'b1;
        step(); see("dd_0", 9, 1'b1);
        ev_dead = 1'b0; up = 1'b1;
        for (int i = 0; i < 50; i++) begin
            ev_tp   = (i == 10);
            ev_dead = (i == 20);
            step(); see("dd_latch", 9, 1'b1);
        end
        ev_tp = 1'b0; ev_dead = 1'b0; up = 1'b0;
        ev_clear = 1'b1;
        step(); see("cl_0", 10, 1'b1);
        ev_clear = 1'b0; ev_dead = 1'b1;
        step(); see("cl_dead_ign", 10, 1'b1);
        ev_dead = 1'b0; ev_start = 1'b1;
        step(); see("ex_st0", 7, 1'b1);
        ev_start = 1'b0;
        for (int i = 1; i < 4; i++) begin step(); see("ex_hold", 7, 1'b1); end
        for (int i = 0; i < 2; i++) begin step(); see("ex_gap", 0, 1'b1); end
        step(); see("ex_idle", 0, 1'b0);
        step(); see("ex_no_pend", 0, 1'b0);

        // DEAD preempts a gap; CLEAR latched; START with CLEAR ignored
        ev_start = 1'b1;
        step(); see("gp_st", 7, 1'b1);
        ev_start = 1'b0;
        repeat (3) step();
        step(); see("gp_gap", 0, 1'b1);
        ev_dead = 1'b1;
        step(); see("gp_dead", 9, 1'b1);
        ev_dead = 1'b0; ev_clear = 1'b1;
        step(); see("gp_clr", 10, 1'b1);
        step(); see("gp_clr2", 10, 1'b1);
        ev_start = 1'b1;
        step(); see("gp_st_clr", 10, 1'b1);
        ev_start = 1'b0; ev_clear = 1'b0;
        step(); see("gp_hold", 10, 1'b1);
        #2 reset_n = 1'b0;
        #1 see("rst_async1", 0, 1'b0);
        #3 reset_n = 1'b1;
        step(); see("rst_after1", 0, 1'b0);

        // DEAD and START together: DEAD latched, START discarded
        ev_dead = 1'b1; ev_start = 1'b1;
        step(); see("ds_0", 9, 1'b1);
        ev_dead = 1'b0; ev_start = 1'b0;
        step(); see("ds_1", 9, 1'b1);
        step(); see("ds_2", 9, 1'b1);
        #2 reset_n = 1'b0;
        #1 see("rst_async2", 0, 1'b0);
        #3 reset_n = 1'b1;
        step(); see("rst_after2", 0, 1'b0);
        step(); see("rst_after3", 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
